// File: rtl/prg_fetch_ctrl.sv
// prg_fetch_ctrl: fetch/decode sequencer for the 4-bit trainer CPU program ROM
module prg_fetch_ctrl #(
    parameter int          PC_W   = 4,
    parameter int          CODE_W = 8,
    parameter logic [3:0]  OP_JMP = 4'hD,
    parameter logic [3:0]  OP_JNC = 4'hE
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              ce_i,
    input  logic              restart_i,
    input  logic [CODE_W-1:0] mc_code_i,
    input  logic              carry_i,
    output logic [PC_W-1:0]   pcnt_o,
    output logic [3:0]        opcode_o,
    output logic [3:0]        operand_o,
    output logic              exec_o,
    output logic              halt_o
);
    typedef enum logic [1:0] {FETCH, DECODE, EXEC_S, HALT_S} state_t;

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic              halt_q, halt_d;
    logic              exec_d;
    logic [PC_W-1:0]   target;

    assign target    = PC_W'(ir_q[3:0]);
    assign pcnt_o    = pc_q;
    assign opcode_o  = ir_q[7:4];
    assign operand_o = ir_q[3:0];
    assign exec_o    = exec_d;
    assign halt_o    = halt_q;

    // next-state logic: restart dominates, otherwise advance only on CE; HALT_S parks
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        halt_d  = halt_q;
        exec_d  = 1'b0;
        if (restart_i) begin
            state_d = FETCH;
            pc_d    = '0;
            halt_d  = 1'b0;
        end else if (ce_i) begin
            case (state_q)
                FETCH: begin
                    ir_d    = {mc_code_i[CODE_W-1 -: 4], mc_code_i[3:0]};
                    state_d = DECODE;
                end
                DECODE: begin
                    if (ir_q[7:4] == OP_JMP) begin
                        if (target == pc_q) begin
                            state_d = HALT_S;
                            halt_d  = 1'b1;
                        end else begin
                            pc_d    = target;
                            state_d = FETCH;
                        end
                    end else if (ir_q[7:4] == OP_JNC) begin
                        pc_d    = carry_i ? pc_q + PC_ONE : target;
                        state_d = FETCH;
                    end else begin
                        state_d = EXEC_S;
                    end
                end
                EXEC_S: begin
                    exec_d  = 1'b1;
                    pc_d    = pc_q + PC_ONE;
                    state_d = FETCH;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // state, program counter, instruction register and halt flag
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            halt_q  <= halt_d;
        end
    end
endmodule

// File: tb/tb_prg_fetch_ctrl.sv
// tb_prg_fetch_ctrl: directed scoreboard bench for the fetch/decode sequencer
module tb_prg_fetch_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce = 1'b0;
    logic       restart = 1'b0;
    logic       carry = 1'b0;
    logic [7:0] mc_code;
    logic [3:0] pcnt, opcode, operand;
    logic       exec, halt;
    logic [7:0] rom [16];
    logic [11:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    assign mc_code = rom[pcnt];

    prg_fetch_ctrl dut (
        .clk_i(clk), .rst_n_i(rst_n), .ce_i(ce), .restart_i(restart),
        .mc_code_i(mc_code), .carry_i(carry), .pcnt_o(pcnt),
        .opcode_o(opcode), .operand_o(operand), .exec_o(exec), .halt_o(halt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // monitor: every EXEC strobe must match the oldest expected {opcode, operand, pcnt}
    always @(negedge clk) begin
        if (exec) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_exec", {opcode, operand, pcnt}, 0);
                if ({opcode, operand, pcnt} == 12'h0) begin
                    errors++;
                    $display("FAIL unexpected_exec: got exec=1 expected none");
                end
            end else begin
                chk("exec_payload", {opcode, operand, pcnt}, exp_q.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        rom[0] = 8'h90;
        rom[1] = 8'hD0;
        step(2);
        rst_n = 1'b1;
        chk("rst_pcnt", pcnt, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_operand", operand, 0);
        chk("rst_halt", halt, 0);
        chk("rst_exec", exec, 0);
        exp_q.push_back({4'h9, 4'h0, 4'h0});
        ce = 1'b1;
        step(); chk("t1_pc_c1", pcnt, 0);
        step(); chk("t1_pc_c2", pcnt, 0);
        step(); chk("t1_pc_after", pcnt, 1);
        step(2);
        chk("t2_pc", pcnt, 0);
        chk("t2_halt", halt, 0);
        chk("t2_opcode", opcode, 4'hD);
        rom[0] = 8'hD3;
        step(2); chk("jmp3_pc", pcnt, 3);
        rom[3] = 8'hE8;
        rom[8] = 8'hD3;
        carry = 1'b0;
        step(2);
        chk("jnc_c0_pc", pcnt, 8);
        chk("jnc_opcode", opcode, 4'hE);
        chk("jnc_operand", operand, 4'h8);
        step(2); chk("back3_pc", pcnt, 3);
        carry = 1'b1;
        step(2); chk("jnc_c1_pc", pcnt, 4);
        carry = 1'b0;
        rom[4] = 8'hDF;
        rom[15] = 8'h11;
        step(2); chk("jmpF_pc", pcnt, 15);
        exp_q.push_back({4'h1, 4'h1, 4'hF});
        step(3); chk("wrap_pc", pcnt, 0);
        rom[0] = 8'hDF;
        rom[15] = 8'hDF;
        step(2); chk("pre_halt_pc", pcnt, 15);
        step(2);
        chk("halt_set", halt, 1);
        chk("halt_pc", pcnt, 15);
        for (int i = 0; i < 20; i++) begin
            ce = 1'($urandom_range(0, 1));
            step();
            chk("halt_hold_pc", pcnt, 15);
            chk("halt_hold", halt, 1);
        end
        restart = 1'b1;
        ce = 1'b1;
        step();
        restart = 1'b0;
        ce = 1'b0;
        chk("restart_pc", pcnt, 0);
        chk("restart_halt", halt, 0);
        chk("restart_ir", {opcode, operand}, 8'hDF);
        rom[0] = 8'h5A;
        exp_q.push_back({4'h5, 4'hA, 4'h0});
        ce = 1'b1; step();
        ce = 1'b0; step(); chk("ce0_dec_pc", pcnt, 0);
        ce = 1'b1; step();
        ce = 1'b0; step(); chk("ce0_exec_pc", pcnt, 0);
        ce = 1'b1; step();
        ce = 1'b0; chk("ce_toggle_pc", pcnt, 1);
        chk("ce_toggle_ir", {opcode, operand}, 8'h5A);
        rom[1] = 8'h37;
        ce = 1'b1;
        step(2);
        rst_n = 1'b0;
        #1;
        chk("arst_exec", exec, 0);
        chk("arst_pc", pcnt, 0);
        chk("arst_opcode", opcode, 0);
        chk("arst_operand", operand, 0);
        chk("arst_halt", halt, 0);
        ce = 1'b0;
        #1 rst_n = 1'b1;
        step(2);
        chk("post_arst_pc", pcnt, 0);
        chk("exec_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
